// File: rtl/avg_median_pkg.sv
// Types and helpers shared by the AverageAndMedian filter stages.
package avg_median_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    function automatic int unsigned acc_width(input int unsigned w, input int unsigned log2d);
        return w + log2d;
    endfunction

    // Sign-extends the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int unsigned w);
        return $signed(v << (32 - w)) >>> (32 - w);
    endfunction

endpackage

// File: rtl/moving_average_filter_if.sv
// Sample stream into the boxcar filter and windowed mean out of it.
interface moving_average_filter_if
    import avg_median_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W
);
    logic                    Clear;
    logic signed [WIDTH-1:0] Input;
    logic                    InValid;
    logic signed [WIDTH-1:0] Output;
    logic                    OutValid;
    logic                    Filled;

    modport master (
        output Clear, Input, InValid,
        input  Output, OutValid, Filled
    );

    modport slave (
        input  Clear, Input, InValid,
        output Output, OutValid, Filled
    );
endinterface

// File: rtl/moving_average_filter_sample_ring.sv
// Circular window of the last DEPTH samples; exposes the slot about to be overwritten.
module sample_ring
    import avg_median_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_W,
    parameter int unsigned LOG2_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_wr_en,
    input  logic signed [WIDTH-1:0] i_data,
    output logic signed [WIDTH-1:0] o_oldest
);
    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE = 1;

    logic signed [WIDTH-1:0] r_buf [DEPTH];
    logic [LOG2_DEPTH-1:0]   r_wr_ptr;

    // Power-of-two depth: the pointer wraps by plain overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en && !i_clear) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    assign o_oldest = r_buf[r_wr_ptr];
endmodule

// File: rtl/moving_average_filter.sv
// Boxcar filter: registered mean of the last 2^LOG2_DEPTH accepted samples.
module moving_average_filter
    import avg_median_pkg::*;
#(
    parameter int unsigned WIDTH      = SAMPLE_W,
    parameter int unsigned LOG2_DEPTH = 4
) (
    input logic                    Clk,
    input logic                    Reset,
    moving_average_filter_if.slave bus
);
    localparam int unsigned ACC_W = acc_width(WIDTH, LOG2_DEPTH);
    localparam logic [LOG2_DEPTH:0] CNT_ONE = 1;

    logic signed [ACC_W-1:0] r_sum;
    logic [LOG2_DEPTH:0]     r_count;
    logic                    r_pend;
    logic signed [WIDTH-1:0] r_out;
    logic                    r_out_valid;

    logic                    w_filled;
    logic signed [WIDTH-1:0] w_oldest;
    logic signed [ACC_W-1:0] w_in_ext;
    logic signed [ACC_W-1:0] w_old_ext;

    sample_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_clear  (bus.Clear),
        .i_wr_en  (bus.InValid),
        .i_data   (bus.Input),
        .o_oldest (w_oldest)
    );

    // Count saturates at DEPTH, so its MSB alone marks a full window.
    assign w_filled  = r_count[LOG2_DEPTH];
    assign w_in_ext  = ACC_W'(sext(32'(bus.Input), WIDTH));
    assign w_old_ext = w_filled ? ACC_W'(sext(32'(w_oldest), WIDTH)) : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sum       <= '0;
            r_count     <= '0;
            r_pend      <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.Clear) begin
            // The restart marker replaces any result still in flight.
            r_sum       <= '0;
            r_count     <= '0;
            r_pend      <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= r_pend;
            if (r_pend) begin
                r_out <= WIDTH'(r_sum >>> LOG2_DEPTH);
            end
            r_pend <= bus.InValid;
            if (bus.InValid) begin
                r_sum <= r_sum + w_in_ext - w_old_ext;
                if (!w_filled) begin
                    r_count <= r_count + CNT_ONE;
                end
            end
        end
    end

    assign bus.Output   = r_out;
    assign bus.OutValid = r_out_valid;
    assign bus.Filled   = w_filled;
endmodule

// File: tb/tb_moving_average_filter.sv
// Directed checks of moving_average_filter with a 4-tap window.
module tb_moving_average_filter;
    import avg_median_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_fail;

    moving_average_filter_if #(.WIDTH(16)) bus ();

    moving_average_filter #(
        .WIDTH      (16),
        .LOG2_DEPTH (2)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic signed [15:0] d, input logic c);
        bus.InValid = v;
        bus.Input   = d;
        bus.Clear   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic signed [31:0] o, input logic v);
        check({tag, "_out"}, 32'(bus.Output), o);
        check({tag, "_vld"}, 32'(bus.OutValid), 32'(v));
    endtask

    task automatic do_reset();
        bus.InValid = 1'b0;
        bus.Clear   = 1'b0;
        bus.Input   = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic ramp100(input string pfx);
        cycle(1'b1, 16'sd100, 1'b0);
        check({pfx, "_e1_vld"}, 32'(bus.OutValid), 0);
        check({pfx, "_e1_fill"}, 32'(bus.Filled), 0);
        for (int e = 2; e <= 6; e++) begin
            cycle(1'b1, 16'sd100, 1'b0);
            check_out($sformatf("%s_e%0d", pfx, e), ((e - 1 > 4) ? 4 : e - 1) * 25, 1'b1);
            check($sformatf("%s_e%0d_fill", pfx, e), 32'(bus.Filled), (e >= 4) ? 1 : 0);
        end
        cycle(1'b0, 16'sd0, 1'b0);
    endtask

    logic signed [15:0] s3_in  [8];
    logic signed [31:0] s3_exp [8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst         = 1'b1;
        bus.InValid = 1'b0;
        bus.Clear   = 1'b0;
        bus.Input   = '0;
        #2;
        check("rst_out", 32'(bus.Output), 0);
        check("rst_vld", 32'(bus.OutValid), 0);
        check("rst_fill", 32'(bus.Filled), 0);
        do_reset();

        // Constant 100 ramps up through warm-up then settles.
        ramp100("s1");

        // Floor rounding on negative constant input.
        do_reset();
        cycle(1'b1, -16'sd3, 1'b0);
        for (int e = 2; e <= 5; e++) begin
            cycle(1'b1, -16'sd3, 1'b0);
            check_out($sformatf("s2_e%0d", e), (e == 2) ? -1 : (e == 3) ? -2 : -3, 1'b1);
        end

        // Full-scale extremes: accumulator must not wrap.
        do_reset();
        s3_exp = '{8191, 16383, 24575, 32767, 16383, -1, -16385, -32768};
        for (int i = 0; i < 8; i++) s3_in[i] = (i < 4) ? 16'sh7FFF : 16'sh8000;
        cycle(1'b1, s3_in[0], 1'b0);
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, s3_in[i], 1'b0);
            check_out($sformatf("s3_%0d", i - 1), s3_exp[i - 1], 1'b1);
        end
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s3_7", s3_exp[7], 1'b1);

        // Idle gaps: single strobes, output holds between them.
        do_reset();
        cycle(1'b1, 16'sd4, 1'b0);
        check("s4_e1_vld", 32'(bus.OutValid), 0);
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s4_e2", 1, 1'b1);
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s4_e3", 1, 1'b0);
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s4_e4", 1, 1'b0);
        cycle(1'b1, 16'sd8, 1'b0);
        check_out("s4_e5", 1, 1'b0);
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s4_e6", 3, 1'b1);
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s4_e7", 3, 1'b0);

        // Clear with a concurrent accept and a pending result.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'sd100, 1'b0);
        check("s5_filled", 32'(bus.Filled), 1);
        cycle(1'b1, 16'sd500, 1'b1);
        check_out("s5_clr", 0, 1'b1);
        check("s5_clr_fill", 32'(bus.Filled), 0);
        cycle(1'b1, 16'sd40, 1'b0);
        check_out("s5_acc", 0, 1'b0);
        cycle(1'b0, 16'sd0, 1'b0);
        check_out("s5_res", 10, 1'b1);
        check("s5_res_fill", 32'(bus.Filled), 0);

        // Asynchronous reset mid-stream, then an identical restart.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'sd100, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("s6_out", 32'(bus.Output), 0);
        check("s6_vld", 32'(bus.OutValid), 0);
        check("s6_fill", 32'(bus.Filled), 0);
        bus.InValid = 1'b0;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("s6_idle_vld", 32'(bus.OutValid), 0);
        ramp100("s6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
